// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT frame sequencer.
//   FFT_NPTS    : frame length (the core is fixed at 16 points)
//   FFT_WIDTH   : packed complex sample width {re, im}, each half Q1.17
//   FFT_TIMEOUT : maximum cycles spent waiting for the core
//   FFT_CNT_W   : width of the drained-frame counter
//   cplx_t      : one packed complex sample
//   seq_state_t : sequencer states
package fft_pkg;

  localparam int FFT_NPTS    = 16;
  localparam int FFT_WIDTH   = 36;
  localparam int FFT_TIMEOUT = 64;
  localparam int FFT_CNT_W   = 16;

  typedef logic signed [FFT_WIDTH-1:0] cplx_t;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    KICK    = 3'd1,
    WAIT    = 3'd2,
    RELEASE = 3'd3,
    DRAIN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/fft16_sample_buf.sv
// 16-entry sample register file.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset, clears every entry
//   wr_en     : write wr_data into entry wr_idx
//   wr_idx    : write index
//   wr_data   : write data
//   load_en   : load all entries in parallel from load_data (wins over wr_en)
//   load_data : flat image, slice k = entry k
//   rd_idx    : read index
//   rd_data   : entry rd_idx (combinational)
//   flat      : flat view of all entries, slice k = entry k
// Built from flops rather than RAM because every entry is visible at once.
module fft16_sample_buf #(
  parameter int WIDTH = 36,
  parameter int NPTS  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [3:0]            wr_idx,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  load_en,
  input  logic [NPTS*WIDTH-1:0] load_data,
  input  logic [3:0]            rd_idx,
  output logic [WIDTH-1:0]      rd_data,
  output logic [NPTS*WIDTH-1:0] flat
);

  logic [WIDTH-1:0] words [NPTS];

  generate
    for (genvar gi = 0; gi < NPTS; gi++) begin : g_entry
      logic [WIDTH-1:0] word_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          word_reg <= '0;
        end else if (load_en) begin
          word_reg <= load_data[gi*WIDTH +: WIDTH];
        end else if (wr_en && (wr_idx == 4'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign words[gi]                  = word_reg;
      assign flat[gi*WIDTH +: WIDTH]    = word_reg;
    end
  endgenerate

  assign rd_data = words[rd_idx];

endmodule

// File: rtl/fft16_frame_sequencer.sv
// Streaming front/back end for the 16-point FFT core: collects a frame of
// samples, launches the core, captures its results and streams them out in
// bin order, then returns the core to idle.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   abort        : synchronous abort of the current frame
//   in_valid/in_ready/in_data     : sample input stream (ready only in FILL)
//   out_valid/out_ready/out_data  : bin output stream (valid only in DRAIN)
//   out_last     : marks bin 15
//   fft_f        : frame to the core, slice k = sample k
//   fft_start    : one-cycle launch pulse
//   fft_clear    : one-cycle core reset pulse
//   fft_F        : core results, slice k = bin k
//   fft_done     : core results valid
//   busy         : anything other than an empty FILL
//   err_timeout  : sticky core-timeout flag
//   frame_count  : frames fully drained (wraps)
module fft16_frame_sequencer
  import fft_pkg::*;
#(
  parameter int WIDTH   = FFT_WIDTH,
  parameter int NPTS    = FFT_NPTS,
  parameter int TIMEOUT = FFT_TIMEOUT,
  parameter int CNT_W   = FFT_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [NPTS*WIDTH-1:0] fft_f,
  output logic                  fft_start,
  output logic                  fft_clear,
  input  logic [NPTS*WIDTH-1:0] fft_F,
  input  logic                  fft_done,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [CNT_W-1:0]      frame_count
);

  localparam int WCNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [3:0] LAST_IDX = 4'(NPTS - 1);

  seq_state_t        state_reg, state_next;
  logic [3:0]        wr_idx_reg, wr_idx_next;
  logic [3:0]        rd_idx_reg, rd_idx_next;
  logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              captured_reg, captured_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;

  logic ibuf_wr;
  logic obuf_load;
  logic [WIDTH-1:0]      ibuf_rd_unused;
  logic [NPTS*WIDTH-1:0] obuf_flat_unused;

  fft16_sample_buf #(.WIDTH(WIDTH), .NPTS(NPTS)) u_ibuf (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (ibuf_wr),
    .wr_idx    (wr_idx_reg),
    .wr_data   (in_data),
    .load_en   (1'b0),
    .load_data ('0),
    .rd_idx    (4'd0),
    .rd_data   (ibuf_rd_unused),
    .flat      (fft_f)
  );

  fft16_sample_buf #(.WIDTH(WIDTH), .NPTS(NPTS)) u_obuf (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_idx    (4'd0),
    .wr_data   ('0),
    .load_en   (obuf_load),
    .load_data (fft_F),
    .rd_idx    (rd_idx_reg),
    .rd_data   (out_data),
    .flat      (obuf_flat_unused)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= FILL;
      wr_idx_reg    <= '0;
      rd_idx_reg    <= '0;
      wait_cnt_reg  <= '0;
      captured_reg  <= 1'b0;
      err_reg       <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wr_idx_reg    <= wr_idx_next;
      rd_idx_reg    <= rd_idx_next;
      wait_cnt_reg  <= wait_cnt_next;
      captured_reg  <= captured_next;
      err_reg       <= err_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_idx_next    = wr_idx_reg;
    rd_idx_next    = rd_idx_reg;
    wait_cnt_next  = wait_cnt_reg;
    captured_next  = captured_reg;
    err_next       = err_reg;
    frame_cnt_next = frame_cnt_reg;
    ibuf_wr        = 1'b0;
    obuf_load      = 1'b0;
    fft_start      = 1'b0;
    fft_clear      = 1'b0;

    case (state_reg)
      FILL: begin
        if (!abort && in_valid) begin
          ibuf_wr     = 1'b1;
          wr_idx_next = wr_idx_reg + 4'd1;  // wraps to 0 after the last sample
          if (wr_idx_reg == LAST_IDX) begin
            state_next = KICK;
          end
        end
      end

      KICK: begin
        fft_start     = 1'b1;
        wait_cnt_next = '0;
        state_next    = abort ? RELEASE : WAIT;
        captured_next = 1'b0;
      end

      WAIT: begin
        wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
        if (abort) begin
          captured_next = 1'b0;
          state_next    = RELEASE;
        end else if (fft_done) begin
          // done takes precedence over a coinciding timeout
          obuf_load     = 1'b1;
          captured_next = 1'b1;
          state_next    = RELEASE;
        end else if (wait_cnt_reg == WCNT_W'(TIMEOUT - 1)) begin
          err_next      = 1'b1;
          captured_next = 1'b0;
          state_next    = RELEASE;
        end
      end

      RELEASE: begin
        fft_clear     = 1'b1;
        state_next    = (captured_reg && !abort) ? DRAIN : FILL;
        captured_next = 1'b0;
      end

      DRAIN: begin
        if (abort) begin
          captured_next = 1'b0;
          state_next    = RELEASE;
        end else if (out_ready) begin
          if (rd_idx_reg == LAST_IDX) begin
            rd_idx_next    = '0;
            frame_cnt_next = frame_cnt_reg + CNT_W'(1);
            state_next     = FILL;
          end else begin
            rd_idx_next = rd_idx_reg + 4'd1;
          end
        end
      end

      default: begin
        // unreachable encoding: recover to an idle core
        fft_clear     = 1'b1;
        captured_next = 1'b0;
        wr_idx_next   = '0;
        rd_idx_next   = '0;
        state_next    = FILL;
      end
    endcase

    if (abort) begin
      wr_idx_next = '0;
      rd_idx_next = '0;
    end
  end

  // in_ready stays low while reset is held even though the state is FILL
  assign in_ready    = (state_reg == FILL) && reset;
  assign out_valid   = (state_reg == DRAIN);
  assign out_last    = (state_reg == DRAIN) && (rd_idx_reg == LAST_IDX);
  assign busy        = !((state_reg == FILL) && (wr_idx_reg == 4'd0));
  assign err_timeout = err_reg;
  assign frame_count = frame_cnt_reg;

endmodule

// File: tb/tb_fft16_frame_sequencer.sv
module tb_fft16_frame_sequencer;

  localparam int W = 36;
  localparam int N = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           abort = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [N*W-1:0] fft_f;
  logic           fft_start;
  logic           fft_clear;
  logic [N*W-1:0] fft_F = '0;
  logic           fft_done = 1'b0;
  logic           busy;
  logic           err_timeout;
  logic [15:0]    frame_count;

  int checks = 0;
  int failures = 0;
  bit core_en = 1'b1;
  int core_cnt = 0;

  fft16_frame_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .abort       (abort),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .fft_f       (fft_f),
    .fft_start   (fft_start),
    .fft_clear   (fft_clear),
    .fft_F       (fft_F),
    .fft_done    (fft_done),
    .busy        (busy),
    .err_timeout (err_timeout),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  // Core model: fft_done pulses one cycle, six cycles after fft_start.
  initial begin
    forever begin
      @(negedge clock);
      fft_done = 1'b0;
      if (!reset || fft_clear) begin
        core_cnt = 0;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) fft_done = 1'b1;
      end else if (fft_start && core_en) begin
        core_cnt = 6;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_core_results(input int base);
    for (int k = 0; k < N; k++) fft_F[k*W +: W] = W'(base + k);
  endtask

  // Samples carry re = base+k, im = 0.
  task automatic send_samples(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      int budget = 0;
      in_valid = 1'b1;
      in_data  = W'(base + k) << 18;
      while (in_ready !== 1'b1 && budget < 50) begin
        tick;
        budget++;
      end
      if (budget >= 50) begin
        checks++;
        failures++;
        $display("FAIL send_in_ready_timeout sample=%0d in_ready=%b required=1", k, in_ready);
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid;
    int budget = 0;
    while (out_valid !== 1'b1 && budget < 40) begin
      tick;
      budget++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL wait_out_valid out_valid=%b required=1 after %0d cycles", out_valid, budget);
    end
  endtask

  task automatic drain_bins(input int base, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(base + k) || out_last !== (k == N - 1)) begin
        failures++;
        $display("FAIL %s bin=%0d valid=%b data=%0d last=%b required valid=1 data=%0d last=%b",
                 tag, k, out_valid, out_data, out_last, base + k, (k == N - 1));
      end
      tick;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || fft_start !== 1'b0 ||
        fft_clear !== 1'b0 || err_timeout !== 1'b0 || frame_count !== 16'd0 ||
        fft_f !== '0 || out_data !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs in_ready=%b out_valid=%b busy=%b start=%b clear=%b err=%b cnt=%0d required all 0",
               in_ready, out_valid, busy, fft_start, fft_clear, err_timeout, frame_count);
    end
    tick;
    tick;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b busy=%b required in_ready=1 busy=0", in_ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_fill_kick;
    set_core_results(100);
    send_samples(0, 15);
    checks++;
    if (fft_start !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL fill_15 start=%b in_ready=%b busy=%b required 0 1 1", fft_start, in_ready, busy);
    end
    send_samples(15, 1);
    checks++;
    if (fft_start !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL kick_start start=%b in_ready=%b required start=1 in_ready=0", fft_start, in_ready);
    end
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] exp_s;
      exp_s = W'(k) << 18;
      checks++;
      if (fft_f[k*W +: W] !== exp_s) begin
        failures++;
        $display("FAIL fft_f_slice k=%0d got=%h required=%h", k, fft_f[k*W +: W], exp_s);
      end
    end
    tick;
    checks++;
    if (fft_start !== 1'b0) begin
      failures++;
      $display("FAIL start_width start=%b required=0 one cycle after launch", fft_start);
    end
    $display("test_fill_kick frame launched");
  endtask

  task automatic test_core_done;
    int n = 0;
    while (fft_clear !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (n !== 6 || fft_clear !== 1'b1) begin
      failures++;
      $display("FAIL clear_latency cycles=%0d clear=%b required cycles=6 clear=1", n, fft_clear);
    end
    tick;
    checks++;
    if (fft_clear !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_out clear=%b out_valid=%b in_ready=%b required 0 1 0", fft_clear, out_valid, in_ready);
    end
    drain_bins(100, N, "drain");
    checks++;
    if (frame_count !== 16'd1 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_drain cnt=%0d out_valid=%b in_ready=%b busy=%b required 1 0 1 0",
               frame_count, out_valid, in_ready, busy);
    end
    $display("test_core_done frame drained count=%0d", frame_count);
  endtask

  task automatic test_back_to_back;
    int idx = 0;
    int cyc = 0;
    set_core_results(200);
    send_samples(16, 16);
    wait_out_valid;
    while (idx < N && cyc < 64) begin
      out_ready = (cyc % 2 == 0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(200 + idx) || out_last !== (idx == N - 1) || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure cyc=%0d valid=%b data=%0d last=%b in_ready=%b required 1 %0d %b 0",
                 cyc, out_valid, out_data, out_last, in_ready, 200 + idx, (idx == N - 1));
      end
      tick;
      if (out_ready) idx++;
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (idx !== N || out_valid !== 1'b0 || frame_count !== 16'd2) begin
      failures++;
      $display("FAIL backpressure_end bins=%0d out_valid=%b cnt=%0d required 16 0 2", idx, out_valid, frame_count);
    end
    $display("test_back_to_back frame drained count=%0d", frame_count);
  endtask

  task automatic test_timeout;
    int bad = 0;
    core_en = 1'b0;
    send_samples(32, 16);
    for (int t = 1; t <= 64; t++) begin
      tick;
      if (fft_clear !== 1'b0 || out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early bad_cycles=%0d err=%b required 0 0", bad, err_timeout);
    end
    tick;
    checks++;
    if (err_timeout !== 1'b1 || fft_clear !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire err=%b clear=%b out_valid=%b required 1 1 0", err_timeout, fft_clear, out_valid);
    end
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || fft_clear !== 1'b0 || frame_count !== 16'd2 || err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_after in_ready=%b out_valid=%b clear=%b cnt=%0d err=%b required 1 0 0 2 1",
               in_ready, out_valid, fft_clear, frame_count, err_timeout);
    end
    core_en = 1'b1;
    $display("test_timeout frame dropped err=%b", err_timeout);
  endtask

  task automatic test_abort;
    set_core_results(400);
    send_samples(48, 9);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || fft_clear !== 1'b0) begin
      failures++;
      $display("FAIL abort_fill busy=%b in_ready=%b clear=%b required 0 1 0", busy, in_ready, fft_clear);
    end
    send_samples(64, 16);
    checks++;
    if (fft_start !== 1'b1) begin
      failures++;
      $display("FAIL abort_refill_start start=%b required=1", fft_start);
    end
    for (int k = 0; k < N; k++) begin
      logic [W-1:0] exp_s;
      exp_s = W'(64 + k) << 18;
      checks++;
      if (fft_f[k*W +: W] !== exp_s) begin
        failures++;
        $display("FAIL abort_refill_slice k=%0d got=%h required=%h", k, fft_f[k*W +: W], exp_s);
      end
    end
    wait_out_valid;
    drain_bins(400, 5, "abort_partial");
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if (fft_clear !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_drain clear=%b out_valid=%b required 1 0", fft_clear, out_valid);
    end
    tick;
    checks++;
    if (fft_clear !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'd2) begin
      failures++;
      $display("FAIL abort_after clear=%b out_valid=%b in_ready=%b cnt=%0d required 0 0 1 2",
               fft_clear, out_valid, in_ready, frame_count);
    end
    $display("test_abort frame aborted count=%0d", frame_count);
  endtask

  task automatic test_async_reset;
    set_core_results(500);
    send_samples(80, 16);
    tick;
    tick;
    tick;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || fft_start !== 1'b0 ||
        fft_clear !== 1'b0 || err_timeout !== 1'b0 || frame_count !== 16'd0 ||
        fft_f !== '0 || out_data !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL async_reset in_ready=%b out_valid=%b busy=%b err=%b cnt=%0d required all 0",
               in_ready, out_valid, busy, err_timeout, frame_count);
    end
    tick;
    tick;
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_release in_ready=%b required=1", in_ready);
    end
    send_samples(96, 16);
    wait_out_valid;
    drain_bins(500, N, "post_reset_drain");
    checks++;
    if (frame_count !== 16'd1 || err_timeout !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_end cnt=%0d err=%b out_valid=%b required 1 0 0", frame_count, err_timeout, out_valid);
    end
    $display("test_async_reset frame drained count=%0d", frame_count);
  endtask

  initial begin
    test_reset;
    test_fill_kick;
    test_core_done;
    test_back_to_back;
    test_timeout;
    test_abort;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
